// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU.
//   - opcode constants (ir[7:4])
//   - ALU function codes (shared with the ALU)
//   - register-group write-data mux select codes
//   - controller state encoding, instruction class, decode result struct
package cpu_pkg;

    // Opcodes (ir[7:4]); 4'hD and 4'hE are undefined and execute as NOP
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU function select
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;

    // Register-group write-data mux select
    localparam logic [1:0] ISEL_ALU = 2'd0;
    localparam logic [1:0] ISEL_IMM = 2'd1;
    localparam logic [1:0] ISEL_MEM = 2'd2;

    // Jump condition
    localparam logic [1:0] JC_ALWAYS = 2'd0;
    localparam logic [1:0] JC_Z      = 2'd1;
    localparam logic [1:0] JC_C      = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_IMM    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU  = 3'd0,
        CL_LDI  = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_JMP  = 3'd4,
        CL_NOP  = 3'd5,
        CL_HALT = 3'd6
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu_op;
        logic [1:0] i_sel;
        logic       flag_en;  // latch Z/C in EXEC
        logic [1:0] jcond;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode decoder.
//   opcode  in   4  ir[7:4]
//   dec     out  dec_t  {class, alu_op, i_sel, flag_en, jump condition}
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec.cls     = CL_NOP;
        dec.alu_op  = ALU_PASS;
        dec.i_sel   = ISEL_ALU;
        dec.flag_en = 1'b0;
        dec.jcond   = JC_ALWAYS;
        case (opcode)
            OP_MOV:  dec.cls = CL_ALU;
            OP_ADD:  begin dec.cls = CL_ALU; dec.alu_op = ALU_ADD; dec.flag_en = 1'b1; end
            OP_SUB:  begin dec.cls = CL_ALU; dec.alu_op = ALU_SUB; dec.flag_en = 1'b1; end
            OP_AND:  begin dec.cls = CL_ALU; dec.alu_op = ALU_AND; dec.flag_en = 1'b1; end
            OP_OR:   begin dec.cls = CL_ALU; dec.alu_op = ALU_OR;  dec.flag_en = 1'b1; end
            OP_NOT:  begin dec.cls = CL_ALU; dec.alu_op = ALU_NOT; dec.flag_en = 1'b1; end
            OP_LDI:  begin dec.cls = CL_LDI; dec.i_sel = ISEL_IMM; end
            OP_LD:   begin dec.cls = CL_LD;  dec.i_sel = ISEL_MEM; end
            OP_ST:   dec.cls = CL_ST;
            OP_JMP:  dec.cls = CL_JMP;
            OP_JZ:   begin dec.cls = CL_JMP; dec.jcond = JC_Z; end
            OP_JC:   begin dec.cls = CL_JMP; dec.jcond = JC_C; end
            OP_HALT: dec.cls = CL_HALT;
            default: dec.cls = CL_NOP;
        endcase
    end

endmodule

// File: rtl/instr_ctrl.sv
// instr_ctrl: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
//   clk, rst_n          clock, async active-low reset
//   mem_din             memory read data (instruction / immediate / LD data)
//   s_in                register-group s output, used as LD/ST address
//   zf_in, cf_in        ALU flags for the current operands
//   mem_addr/rd/wr      memory address and strobes
//   raa, rwba, we       register-group addresses and active-low write enable
//   alu_op, i_sel       ALU function and write-data mux select
//   imm, pc, halted     latched operand, program counter, halt indicator
module instr_ctrl
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] mem_din,
    input  logic [7:0] s_in,
    input  logic       zf_in,
    input  logic       cf_in,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] raa,
    output logic [1:0] rwba,
    output logic       we,
    output logic [2:0] alu_op,
    output logic [1:0] i_sel,
    output logic [7:0] imm,
    output logic [7:0] pc,
    output logic       halted
);

    state_t     state, state_nx;
    logic [7:0] ir;
    logic       zf, cf;
    dec_t       dec;
    logic       jump_taken;
    logic       rd_s, wr_s, we_s;

    instr_decode u_dec (
        .opcode (ir[7:4]),
        .dec    (dec)
    );

    assign jump_taken = (dec.jcond == JC_ALWAYS) ||
                        (dec.jcond == JC_Z && zf) ||
                        (dec.jcond == JC_C && cf);

    // Next state and per-state strobes
    always_comb begin
        state_nx = state;
        rd_s     = 1'b0;
        wr_s     = 1'b0;
        we_s     = 1'b1;
        case (state)
            S_FETCH: begin
                rd_s     = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (dec.cls)
                    CL_ALU:         state_nx = S_EXEC;
                    CL_LDI, CL_JMP: state_nx = S_IMM;
                    CL_LD, CL_ST:   state_nx = S_MEM;
                    CL_HALT:        state_nx = S_HALTED;
                    default:        state_nx = S_FETCH;
                endcase
            end
            S_EXEC: state_nx = S_WB;
            S_IMM: begin
                rd_s     = 1'b1;
                state_nx = (dec.cls == CL_LDI) ? S_WB : S_FETCH;
            end
            S_MEM: begin
                rd_s     = (dec.cls == CL_LD);
                wr_s     = (dec.cls == CL_ST);
                state_nx = (dec.cls == CL_LD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                we_s     = 1'b0;
                state_nx = S_FETCH;
            end
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Reset forces strobes inactive combinationally, even though the
    // state register already sits in FETCH while rst_n is low.
    assign mem_rd   = rd_s & rst_n;
    assign mem_wr   = wr_s & rst_n;
    assign we       = we_s | ~rst_n;
    assign mem_addr = (state == S_MEM) ? s_in : pc;
    assign raa      = ir[3:2];
    assign rwba     = ir[1:0];
    assign alu_op   = dec.alu_op;
    assign i_sel    = dec.i_sel;
    assign halted   = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 8'h00;
            imm   <= 8'h00;
            zf    <= 1'b0;
            cf    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: begin
                    ir <= mem_din;
                    pc <= pc + 8'd1;
                end
                S_IMM: begin
                    imm <= mem_din;
                    pc  <= (dec.cls == CL_JMP && jump_taken) ? mem_din : pc + 8'd1;
                end
                S_EXEC: begin
                    if (dec.flag_en) begin
                        zf <= zf_in;
                        cf <= cf_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// tb_instr_ctrl: directed self-checking bench for instr_ctrl.
// Program memory is modelled as a 256-byte array read combinationally.
module tb_instr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_din, s_in;
    logic       zf_in, cf_in;
    logic [7:0] mem_addr;
    logic       mem_rd, mem_wr;
    logic [1:0] raa, rwba;
    logic       we;
    logic [2:0] alu_op;
    logic [1:0] i_sel;
    logic [7:0] imm, pc;
    logic       halted;

    logic [7:0] mem [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    assign mem_din = mem[mem_addr];

    instr_ctrl #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .mem_din(mem_din), .s_in(s_in),
        .zf_in(zf_in), .cf_in(cf_in), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .raa(raa), .rwba(rwba), .we(we), .alu_op(alu_op),
        .i_sel(i_sel), .imm(imm), .pc(pc), .halted(halted)
    );

    // advance one cycle, sampling mid-cycle on the negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // hold reset for two cycles, release on a negedge: the cycle that
    // follows is cycle 1 (FETCH at pc=00)
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[8'h00] = 8'h21;  // ADD r0 -> r1
        zf_in = 1'b0; cf_in = 1'b0; s_in = 8'h00;
        do_reset();
        tests++;
        if (halted !== 1'b0 || pc !== 8'h00 || imm !== 8'h00 || we !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: halted=%b pc=%h imm=%h we=%b, want 0 00 00 1", halted, pc, imm, we);
        end
        tick();  // DECODE
        tick();  // EXEC
        rst_n = 1'b0;
        #1;
        tests++;
        if (we !== 1'b1 || pc !== 8'h00 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_exec: we=%b pc=%h rd=%b wr=%b, want 1 00 0 0", we, pc, mem_rd, mem_wr);
        end
        tick();
        tests++;
        if (we !== 1'b1 || mem_rd !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: we=%b rd=%b, want 1 0", we, mem_rd);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || we !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_fetch: rd=%b addr=%h we=%b, want 1 00 1", mem_rd, mem_addr, we);
        end
    endtask

    task automatic test_ldi();
        clear_mem();
        mem[8'h00] = 8'h71;  // LDI r1
        mem[8'h01] = 8'h5A;
        do_reset();
        tick();  // DECODE
        tests++;
        if (rwba !== 2'b01 || raa !== 2'b00 || we !== 1'b1) begin
            fails++;
            $display("FAIL ldi_decode: rwba=%b raa=%b we=%b, want 01 00 1", rwba, raa, we);
        end
        tick();  // IMM
        tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h01 || we !== 1'b1) begin
            fails++;
            $display("FAIL ldi_imm: rd=%b addr=%h we=%b, want 1 01 1", mem_rd, mem_addr, we);
        end
        tick();  // WB
        tests++;
        if (we !== 1'b0 || rwba !== 2'b01 || i_sel !== 2'd1 || imm !== 8'h5A) begin
            fails++;
            $display("FAIL ldi_wb: we=%b rwba=%b i_sel=%0d imm=%h, want 0 01 1 5a", we, rwba, i_sel, imm);
        end
        tick();  // FETCH
        tests++;
        if (pc !== 8'h02 || we !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 8'h02) begin
            fails++;
            $display("FAIL ldi_next_fetch: pc=%h we=%b rd=%b addr=%h, want 02 1 1 02", pc, we, mem_rd, mem_addr);
        end
    endtask

    task automatic test_alu_flags();
        clear_mem();
        mem[8'h00] = 8'h21;  // ADD r0 -> r1
        mem[8'h01] = 8'hB0;  // JZ 10
        mem[8'h02] = 8'h10;
        mem[8'h10] = 8'hC0;  // JC 33
        mem[8'h11] = 8'h33;
        zf_in = 1'b1; cf_in = 1'b1;
        do_reset();
        tick();  // DECODE
        tests++;
        if (alu_op !== 3'd1 || raa !== 2'b00 || rwba !== 2'b01 || we !== 1'b1) begin
            fails++;
            $display("FAIL add_decode: alu_op=%0d raa=%b rwba=%b we=%b, want 1 00 01 1", alu_op, raa, rwba, we);
        end
        tick();  // EXEC
        tests++;
        if (we !== 1'b1 || alu_op !== 3'd1) begin
            fails++;
            $display("FAIL add_exec: we=%b alu_op=%0d, want 1 1", we, alu_op);
        end
        tick();  // WB
        zf_in = 1'b0; cf_in = 1'b0;  // flags must already be latched
        tests++;
        if (we !== 1'b0 || i_sel !== 2'd0) begin
            fails++;
            $display("FAIL add_wb: we=%b i_sel=%0d, want 0 0", we, i_sel);
        end
        tick();  // FETCH
        tests++;
        if (we !== 1'b1 || pc !== 8'h01) begin
            fails++;
            $display("FAIL add_after_wb: we=%b pc=%h, want 1 01", we, pc);
        end
        tick(); tick(); tick();  // JZ: DECODE, IMM, FETCH
        tests++;
        if (pc !== 8'h10) begin
            fails++;
            $display("FAIL add_z_latched: pc=%h, want 10", pc);
        end
        tick(); tick(); tick();  // JC: DECODE, IMM, FETCH
        tests++;
        if (pc !== 8'h33) begin
            fails++;
            $display("FAIL add_c_latched: pc=%h, want 33", pc);
        end
    endtask

    task automatic test_jz();
        int we_low;
        // Z=0 after reset: not taken
        clear_mem();
        mem[8'h00] = 8'hB0;
        mem[8'h01] = 8'h40;
        zf_in = 1'b0; cf_in = 1'b0;
        do_reset();
        we_low = 0;
        for (int i = 0; i < 3; i++) begin
            if (we !== 1'b1) we_low++;
            tick();
        end
        tests++;
        if (pc !== 8'h02 || we_low != 0) begin
            fails++;
            $display("FAIL jz_not_taken: pc=%h we_low_cycles=%0d, want 02 0", pc, we_low);
        end
        // ADD sets Z=1, C=0; then JZ taken, then JC not taken
        clear_mem();
        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'hB0;
        mem[8'h02] = 8'h40;
        mem[8'h40] = 8'hC0;
        mem[8'h41] = 8'h77;
        zf_in = 1'b1; cf_in = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();  // ADD done, FETCH at 01
        we_low = 0;
        for (int i = 0; i < 3; i++) begin
            if (we !== 1'b1) we_low++;
            tick();
        end
        tests++;
        if (pc !== 8'h40 || we_low != 0) begin
            fails++;
            $display("FAIL jz_taken: pc=%h we_low_cycles=%0d, want 40 0", pc, we_low);
        end
        tick(); tick(); tick();
        tests++;
        if (pc !== 8'h42) begin
            fails++;
            $display("FAIL jc_not_taken: pc=%h, want 42", pc);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[8'h00] = 8'hA0;  // JMP FF
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h00;  // NOP
        do_reset();
        tick(); tick(); tick();  // FETCH at FF
        tests++;
        if (pc !== 8'hFF || mem_addr !== 8'hFF) begin
            fails++;
            $display("FAIL jmp_ff: pc=%h addr=%h, want ff ff", pc, mem_addr);
        end
        tick(); tick();  // DECODE, FETCH
        tests++;
        if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL nop_wrap: pc=%h addr=%h rd=%b, want 00 00 1", pc, mem_addr, mem_rd);
        end
        // operand fetched from 00 after wrap
        clear_mem();
        mem[8'h00] = 8'h10;  // MOV r0 -> r0, also the jump target below
        mem[8'h01] = 8'hA0;
        mem[8'h02] = 8'hFF;
        mem[8'hFF] = 8'hA0;
        do_reset();
        for (int i = 0; i < 9; i++) tick();  // IMM of JMP at FF
        tests++;
        if (mem_addr !== 8'h00 || mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL operand_wrap_addr: addr=%h rd=%b, want 00 1", mem_addr, mem_rd);
        end
        tick();
        tests++;
        if (pc !== 8'h10) begin
            fails++;
            $display("FAIL operand_wrap_jump: pc=%h, want 10", pc);
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[8'h00] = 8'h89;  // LD r1 <= mem[r2]
        mem[8'h01] = 8'h96;  // ST mem[r1] <= r2
        mem[8'h02] = 8'hD0;  // undefined -> NOP
        mem[8'h30] = 8'hC3;
        s_in = 8'h30;
        do_reset();
        tick(); tick();  // MEM
        tests++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 8'h30 || raa !== 2'b10 || we !== 1'b1) begin
            fails++;
            $display("FAIL ld_mem: rd=%b wr=%b addr=%h raa=%b we=%b, want 1 0 30 10 1", mem_rd, mem_wr, mem_addr, raa, we);
        end
        tick();  // WB
        tests++;
        if (we !== 1'b0 || i_sel !== 2'd2 || rwba !== 2'b01) begin
            fails++;
            $display("FAIL ld_wb: we=%b i_sel=%0d rwba=%b, want 0 2 01", we, i_sel, rwba);
        end
        tick(); tick(); tick();  // ST: FETCH, DECODE, MEM
        tests++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 8'h30 || we !== 1'b1) begin
            fails++;
            $display("FAIL st_mem: wr=%b rd=%b addr=%h we=%b, want 1 0 30 1", mem_wr, mem_rd, mem_addr, we);
        end
        tick();  // FETCH of D0
        tests++;
        if (pc !== 8'h02 || mem_wr !== 1'b0 || mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL st_latency: pc=%h wr=%b rd=%b, want 02 0 1", pc, mem_wr, mem_rd);
        end
        tick(); tick();  // DECODE, FETCH
        tests++;
        if (pc !== 8'h03 || mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL undef_nop: pc=%h rd=%b, want 03 1", pc, mem_rd);
        end
    endtask

    task automatic test_halt();
        int bad;
        clear_mem();
        mem[8'h00] = 8'hF0;
        mem[8'h01] = 8'h21;
        do_reset();
        tick();  // DECODE
        tests++;
        if (halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_early: halted=%b, want 0", halted);
        end
        tick();  // cycle 3
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (halted !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || we !== 1'b1 || pc !== 8'h01)
                bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_sticky: bad_cycles=%0d, want 0 (last halted=%b pc=%h)", bad, halted, pc);
        end
        do_reset();
        tests++;
        if (halted !== 1'b0 || pc !== 8'h00 || mem_rd !== 1'b1) begin
            fails++;
            $display("FAIL halt_reset_clear: halted=%b pc=%h rd=%b, want 0 00 1", halted, pc, mem_rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        zf_in = 1'b0; cf_in = 1'b0; s_in = 8'h00;
        clear_mem();
        test_reset();
        test_ldi();
        test_alu_flags();
        test_jz();
        test_wrap();
        test_back_to_back();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
